// File: rtl/pipe_hazard_pkg.sv
// Shared types for the hazard unit: scoreboard entry, EX source record, match helper.
// Forward-select encoding: 0 = register file, k = stage k, FWD_STAGES+1 = retire buffer.
package pipe_hazard_pkg;

  // Scoreboard address field is fixed-width; instantiations must keep AREG_W <= SB_AW_W.
  localparam int SB_AW_W = 8;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic [SB_AW_W-1:0] aw;
    logic               is_load;
  } sb_entry_t;

  typedef struct packed {
    logic [SB_AW_W-1:0] rs;
    logic [SB_AW_W-1:0] rt;
    logic               use_rs;
    logic               use_rt;
  } ex_src_t;

  localparam sb_entry_t SB_BUBBLE   = '0;
  localparam ex_src_t   EX_SRC_NONE = '0;

  // SEL_W = $clog2(FWD_STAGES+2), evaluated per instance.
  function automatic int sel_w(input int fwd_stages);
    return $clog2(fwd_stages + 2);
  endfunction

  function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW_W-1:0] r);
    return e.valid && e.wr_en && (e.aw == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_mux.sv
// Per-operand forwarding: youngest matching stage wins, retire buffer last, else regfile.
// Purely combinational.
module fwd_mux
  import pipe_hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter bit RB_EN      = 1'b0
) (
  input  logic [SB_AW_W-1:0]           src,
  input  logic                         use_src,
  input  sb_entry_t                    stg_ent [FWD_STAGES],
  input  logic [FWD_STAGES*DATA_W-1:0] stg_data,
  input  logic                         rb_vld,
  input  logic [SB_AW_W-1:0]           rb_aw,
  input  logic [DATA_W-1:0]            rb_dat,
  input  logic [DATA_W-1:0]            rf_dat,
  output logic [DATA_W-1:0]            dat
);

  logic [SEL_W-1:0] sel;

  // Scan oldest to youngest so the youngest match overwrites the selection.
  always_comb begin
    sel = '0;
    if (use_src) begin
      if (RB_EN && rb_vld && (rb_aw == src) && (src != '0)) begin
        sel = SEL_W'(FWD_STAGES + 1);
      end
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (sb_match(stg_ent[k-1], src)) begin
          sel = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    dat = rf_dat;
    if (sel == SEL_W'(FWD_STAGES + 1)) begin
      dat = rb_dat;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        if (sel == SEL_W'(k)) begin
          dat = stg_data[(k-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: issue/stall decision, load-use scoreboard and EX operand forwarding.
// Optional retire-buffer bypass enabled by defining PIPE_HAZARD_RETIRE_BYPASS_EN.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int AREG_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [AREG_W-1:0]            id_rs,
  input  logic [AREG_W-1:0]            id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic                         id_wr_en,
  input  logic [AREG_W-1:0]            id_aw,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            ex_rf_rs,
  input  logic [DATA_W-1:0]            ex_rf_rt,
  input  logic [FWD_STAGES*DATA_W-1:0] stg_data,
  output logic                         stall,
  output logic                         issue,
  output logic [DATA_W-1:0]            ex_rs_data,
  output logic [DATA_W-1:0]            ex_rt_data,
  output logic [31:0]                  stall_cnt
);

  localparam int SEL_W = sel_w(FWD_STAGES);

  sb_entry_t          sb_q [FWD_STAGES+1];
  sb_entry_t          sb_d [FWD_STAGES+1];
  sb_entry_t          sb_fwd [FWD_STAGES];
  ex_src_t            ex_src_q, ex_src_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [SB_AW_W-1:0] id_rs_x, id_rt_x, id_aw_x;
  logic               load_hit;

  assign id_rs_x = SB_AW_W'(id_rs);
  assign id_rt_x = SB_AW_W'(id_rt);
  assign id_aw_x = SB_AW_W'(id_aw);

  // A load at stage s reaches s+1 when the consumer enters EX; it must be at LOAD_STAGE by then.
  always_comb begin
    load_hit = 1'b0;
    for (int s = 0; s <= FWD_STAGES; s++) begin
      if ((s + 1 < LOAD_STAGE) && sb_q[s].is_load) begin
        if ((id_use_rs && sb_match(sb_q[s], id_rs_x)) ||
            (id_use_rt && sb_match(sb_q[s], id_rt_x))) begin
          load_hit = 1'b1;
        end
      end
    end
  end

  assign stall     = id_valid & ~flush & load_hit;
  assign issue     = id_valid & ~stall & ~flush;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    for (int k = 1; k <= FWD_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[0]  = SB_BUBBLE;
    ex_src_d = EX_SRC_NONE;
    if (issue) begin
      sb_d[0]  = '{valid: 1'b1, wr_en: id_wr_en, aw: id_aw_x, is_load: id_is_load};
      ex_src_d = '{rs: id_rs_x, rt: id_rt_x, use_rs: id_use_rs, use_rt: id_use_rt};
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        sb_q[k] <= SB_BUBBLE;
      end
      ex_src_q    <= EX_SRC_NONE;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        sb_q[k] <= sb_d[k];
      end
      ex_src_q    <= ex_src_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int j = 0; j < FWD_STAGES; j++) begin
      sb_fwd[j] = sb_q[j+1];
    end
  end

  logic               rb_vld;
  logic [SB_AW_W-1:0] rb_aw;
  logic [DATA_W-1:0]  rb_dat;

`ifdef PIPE_HAZARD_RETIRE_BYPASS_EN
  localparam bit RB_EN = 1'b1;

  logic               rb_vld_q, rb_vld_d;
  logic [SB_AW_W-1:0] rb_aw_q, rb_aw_d;
  logic [DATA_W-1:0]  rb_dat_q, rb_dat_d;

  // Holds the writer leaving the last stage for one cycle, covering a read-old regfile.
  always_comb begin
    rb_vld_d = sb_q[FWD_STAGES].valid & sb_q[FWD_STAGES].wr_en;
    rb_aw_d  = sb_q[FWD_STAGES].aw;
    rb_dat_d = stg_data[(FWD_STAGES-1)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_vld_q <= 1'b0;
      rb_aw_q  <= '0;
      rb_dat_q <= '0;
    end else begin
      rb_vld_q <= rb_vld_d;
      rb_aw_q  <= rb_aw_d;
      rb_dat_q <= rb_dat_d;
    end
  end

  assign rb_vld = rb_vld_q;
  assign rb_aw  = rb_aw_q;
  assign rb_dat = rb_dat_q;
`else
  localparam bit RB_EN = 1'b0;

  assign rb_vld = 1'b0;
  assign rb_aw  = '0;
  assign rb_dat = '0;
`endif

  fwd_mux #(
    .DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W), .RB_EN(RB_EN)
  ) u_fwd_rs (
    .src(ex_src_q.rs), .use_src(ex_src_q.use_rs), .stg_ent(sb_fwd), .stg_data(stg_data),
    .rb_vld(rb_vld), .rb_aw(rb_aw), .rb_dat(rb_dat), .rf_dat(ex_rf_rs), .dat(ex_rs_data)
  );

  fwd_mux #(
    .DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W), .RB_EN(RB_EN)
  ) u_fwd_rt (
    .src(ex_src_q.rt), .use_src(ex_src_q.use_rt), .stg_ent(sb_fwd), .stg_data(stg_data),
    .rb_vld(rb_vld), .rb_aw(rb_aw), .rb_dat(rb_dat), .rf_dat(ex_rf_rt), .dat(ex_rt_data)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with default parameters (2 forward stages, load at WB).
module tb_pipe_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_aw;
  logic        id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic        flush;
  logic [31:0] ex_rf_rs, ex_rf_rt;
  logic [63:0] stg_data;
  logic        stall, issue;
  logic [31:0] ex_rs_data, ex_rt_data, stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_aw(id_aw),
    .id_is_load(id_is_load), .flush(flush), .ex_rf_rs(ex_rf_rs), .ex_rf_rt(ex_rf_rt),
    .stg_data(stg_data), .stall(stall), .issue(issue), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr,
                        input logic [4:0] aw, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = wr; id_aw = aw; id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_rf_rs = 32'h1234; ex_rf_rt = 32'h5678; stg_data = {32'hCAFE, 32'hBEEF};
    #3;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL reset_issue: got %b exp 0", issue); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
    n_checks++; if (ex_rs_data !== 32'h1234) begin n_errors++; $display("FAIL reset_rs: got %h exp 00001234", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h5678) begin n_errors++; $display("FAIL reset_rt: got %h exp 00005678", ex_rt_data); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    set_id(1, 0, 0, 0, 0, 1, 1, 0); #1;
    n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL chain_issue0: got %b exp 1", issue); end
    tick();
    set_id(1, 1, 1, 1, 1, 1, 2, 0); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL chain_stall: got %b exp 0", stall); end
    n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL chain_issue1: got %b exp 1", issue); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'h99, 32'h5}; ex_rf_rs = 32'h111; ex_rf_rt = 32'h222; #1;
    n_checks++; if (ex_rs_data !== 32'h5) begin n_errors++; $display("FAIL chain_rs: got %h exp 00000005", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h5) begin n_errors++; $display("FAIL chain_rt: got %h exp 00000005", ex_rt_data); end
    drain();
  endtask

  task automatic test_distinct_operands();
    set_id(1, 0, 0, 0, 0, 1, 4, 0); tick();
    set_id(1, 0, 0, 0, 0, 1, 3, 0); tick();
    set_id(1, 3, 4, 1, 1, 1, 5, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'hBB, 32'hAA}; ex_rf_rs = 32'h1; ex_rf_rt = 32'h2; #1;
    n_checks++; if (ex_rs_data !== 32'hAA) begin n_errors++; $display("FAIL distinct_rs: got %h exp 000000aa", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'hBB) begin n_errors++; $display("FAIL distinct_rt: got %h exp 000000bb", ex_rt_data); end
    drain();
  endtask

  task automatic test_back_to_back();
    set_id(1, 0, 0, 0, 0, 1, 8, 0); tick();
    set_id(1, 0, 0, 0, 0, 1, 8, 0); tick();
    set_id(1, 8, 8, 1, 1, 1, 9, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'h22, 32'h11}; #1;
    n_checks++; if (ex_rs_data !== 32'h11) begin n_errors++; $display("FAIL b2b_rs: got %h exp 00000011", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h11) begin n_errors++; $display("FAIL b2b_rt: got %h exp 00000011", ex_rt_data); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 0, 0, 1, 6, 1); tick();
    set_id(1, 6, 0, 1, 1, 1, 7, 0); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
    n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL lu_issue0: got %b exp 0", issue); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL lu_cnt0: got %0d exp 0", stall_cnt); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_release: got %b exp 0", stall); end
    n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL lu_issue1: got %b exp 1", issue); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL lu_cnt1: got %0d exp 1", stall_cnt); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'h66, 32'hDEAD}; ex_rf_rs = 32'h1; ex_rf_rt = 32'h2; #1;
    n_checks++; if (ex_rs_data !== 32'h66) begin n_errors++; $display("FAIL lu_fwd_wb: got %h exp 00000066", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h2) begin n_errors++; $display("FAIL lu_rt_zero: got %h exp 00000002", ex_rt_data); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL lu_cnt_hold: got %0d exp 1", stall_cnt); end
    drain();
  endtask

  task automatic test_reg_zero();
    set_id(1, 0, 0, 0, 0, 1, 0, 1); tick();
    set_id(1, 0, 0, 1, 1, 1, 11, 0); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL zero_stall: got %b exp 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'h88, 32'h77}; ex_rf_rs = 32'h300; ex_rf_rt = 32'h301; #1;
    n_checks++; if (ex_rs_data !== 32'h300) begin n_errors++; $display("FAIL zero_rs: got %h exp 00000300", ex_rs_data); end
    n_checks++; if (ex_rt_data !== 32'h301) begin n_errors++; $display("FAIL zero_rt: got %h exp 00000301", ex_rt_data); end
    drain();
  endtask

  task automatic test_idle_no_stall();
    set_id(1, 0, 0, 0, 0, 1, 12, 1); tick();
    set_id(0, 12, 12, 1, 1, 1, 13, 0); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL idle_stall: got %b exp 0", stall); end
    n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL idle_issue: got %b exp 0", issue); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1, 0, 0, 0, 0, 1, 9, 1); tick();
    set_id(1, 9, 0, 1, 0, 1, 13, 0); #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL fl_pre_stall: got %b exp 1", stall); end
    flush = 1'b1; #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL fl_stall: got %b exp 0", stall); end
    n_checks++; if (issue !== 1'b0) begin n_errors++; $display("FAIL fl_issue: got %b exp 0", issue); end
    tick();
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'hF0, 32'h90}; ex_rf_rs = 32'h400; #1;
    n_checks++; if (ex_rs_data !== 32'h400) begin n_errors++; $display("FAIL fl_bubble: got %h exp 00000400", ex_rs_data); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL fl_cnt: got %0d exp 1", stall_cnt); end
    set_id(1, 9, 0, 1, 0, 1, 13, 0); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL fl_after_stall: got %b exp 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stg_data = {32'h99, 32'h55}; #1;
    n_checks++; if (ex_rs_data !== 32'h99) begin n_errors++; $display("FAIL fl_keep_load: got %h exp 00000099", ex_rs_data); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 0, 0, 0, 0, 1, 10, 1); tick();
    set_id(1, 10, 10, 1, 1, 1, 14, 0); ex_rf_rs = 32'h500; stg_data = {32'hA1, 32'hA0}; #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_pre_stall: got %b exp 1", stall); end
    #1; rst_n = 1'b0; #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d exp 0", stall_cnt); end
    n_checks++; if (ex_rs_data !== 32'h500) begin n_errors++; $display("FAIL rst_rs: got %h exp 00000500", ex_rs_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (issue !== 1'b1) begin n_errors++; $display("FAIL rst_issue: got %b exp 1", issue); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_distinct_operands();
    test_back_to_back();
    test_load_use();
    test_reg_zero();
    test_idle_no_stall();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
